// File: rtl/inv_key_schedule_pkg.sv
// rtl/inv_key_schedule_pkg.sv - shared AES key-schedule types, rcon table and byte/word helpers
package inv_key_schedule_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_Q1   = 3'd1,
    ST_Q2   = 3'd2,
    ST_Q3   = 3'd3,
    ST_Q4   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [3:0] ROUND_MIN = 4'd1;
  localparam logic [3:0] ROUND_MAX = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic round_ok(input logic [3:0] r);
    return (r >= ROUND_MIN) && (r <= ROUND_MAX);
  endfunction

  // Keys are stored row-major: row i is a 32-bit slice, so a column word is gathered across rows.
  function automatic logic [31:0] key_word(input logic [127:0] key, input int c);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = key[127-32*i-8*c -: 8];
    return w;
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input int i);
    return w[31-8*i -: 8];
  endfunction

  function automatic logic [127:0] make_key(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [31:0] w2, input logic [31:0] w3);
    logic [3:0][31:0] w;
    logic [127:0]     k;
    w = {w3, w2, w1, w0};
    k = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) k[127-32*i-8*c -: 8] = w[c][31-8*i -: 8];
    return k;
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// rtl/inv_key_schedule_if.sv - request, result and shared S-box port bundle of the inverse key step
interface inv_key_schedule_if;
  logic         start_in;
  logic [3:0]   round_in;
  logic [127:0] cur_key_in;
  logic [7:0]   sbox_data_in;
  logic [127:0] prev_key_out;
  logic         ready_out;
  logic         busy_out;
  logic         err_out;
  logic [7:0]   sbox_addr_out;
  logic         ce;
  logic         re;

  modport slave (
    input  start_in, round_in, cur_key_in, sbox_data_in,
    output prev_key_out, ready_out, busy_out, err_out, sbox_addr_out, ce, re
  );

  modport master (
    output start_in, round_in, cur_key_in, sbox_data_in,
    input  prev_key_out, ready_out, busy_out, err_out, sbox_addr_out, ce, re
  );
endinterface

// File: rtl/inv_key_schedule.sv
// rtl/inv_key_schedule.sv - one inverse AES-128 key-expansion step K_r -> K_(r-1)
// The four SubWord lookups are serialised through an external S-box with one-cycle read latency.
module inv_key_schedule
  import inv_key_schedule_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  inv_key_schedule_if.slave bus
);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] prev_q, prev_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [7:0]   addr_q, addr_d;
  logic [23:0]  sub_q, sub_d;
  logic         ce_q, ce_d;
  logic         ready_q, ready_d;
  logic         err_q, err_d;

  logic [31:0] p3_new, p3_cur, w0, w1, w2, sub_word, p0;

  assign p3_new = key_word(bus.cur_key_in, 3) ^ key_word(bus.cur_key_in, 2);
  assign w0     = key_word(key_q, 0);
  assign w1     = key_word(key_q, 1);
  assign w2     = key_word(key_q, 2);
  assign p3_cur = key_word(key_q, 3) ^ w2;
  // sub_q ends holding S(b1),S(b2),S(b3); S(b0) is still on the data bus during DONE.
  assign sub_word = {sub_q, bus.sbox_data_in};
  assign p0       = w0 ^ sub_word ^ {rcon_q, 24'h0};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    prev_d  = prev_q;
    rcon_d  = rcon_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    ce_d    = ce_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          if (round_ok(bus.round_in)) begin
            key_d   = bus.cur_key_in;
            rcon_d  = rcon(bus.round_in);
            addr_d  = word_byte(p3_new, 1);
            ce_d    = 1'b0;
            state_d = ST_Q1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_Q1: begin
        sub_d   = {sub_q[15:0], bus.sbox_data_in};
        addr_d  = word_byte(p3_cur, 2);
        state_d = ST_Q2;
      end
      ST_Q2: begin
        sub_d   = {sub_q[15:0], bus.sbox_data_in};
        addr_d  = word_byte(p3_cur, 3);
        state_d = ST_Q3;
      end
      ST_Q3: begin
        sub_d   = {sub_q[15:0], bus.sbox_data_in};
        addr_d  = word_byte(p3_cur, 0);
        state_d = ST_Q4;
      end
      ST_Q4: begin
        sub_d   = {sub_q[15:0], bus.sbox_data_in};
        ce_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        prev_d  = make_key(p0, w1 ^ w0, w2 ^ w1, p3_cur);
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ce_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      prev_q  <= '0;
      rcon_q  <= '0;
      addr_q  <= '0;
      sub_q   <= '0;
      ce_q    <= 1'b1;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      key_q   <= key_d;
      prev_q  <= prev_d;
      rcon_q  <= rcon_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      ce_q    <= ce_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign bus.prev_key_out  = prev_q;
  assign bus.ready_out     = ready_q;
  assign bus.busy_out      = (state_q != ST_IDLE);
  assign bus.err_out       = err_q;
  assign bus.sbox_addr_out = addr_q;
  assign bus.ce            = ce_q;
  assign bus.re            = ce_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb/tb_inv_key_schedule.sv - scoreboard bench for inv_key_schedule with an S-box model
module tb_inv_key_schedule;

  localparam logic [127:0] K_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_R9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ce_low = 0;
  int   re_bad = 0;
  logic [7:0] sbox_q = 8'h00;

  logic [127:0] exp_q[$];
  int           exp_cyc_q[$];
  int           err_cyc_q[$];
  logic [7:0]   rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  inv_key_schedule_if bus ();

  inv_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, b;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Reference keys are FIPS word order {W0,W1,W2,W3}; the port is row-major.
  function automatic logic [127:0] to_port(input logic [127:0] w);
    logic [127:0] p;
    p = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) p[127-32*i-8*c -: 8] = w[127-32*c-8*i -: 8];
    return p;
  endfunction

  function automatic logic [127:0] inv_step_ref(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, p3, t, s;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    t  = {p3[23:0], p3[31:24]};
    s  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    return {w0 ^ s ^ {rcon_tab[r], 24'h0}, w1 ^ w0, w2 ^ w1, p3};
  endfunction

  always @(posedge clk) if (!bus.ce && !bus.re) sbox_q <= sbox(bus.sbox_addr_out);
  assign bus.sbox_data_in = sbox_q;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [127:0] ek;
    int ec;
    if (bus.ce !== bus.re) re_bad++;
    if (bus.ce === 1'b0) ce_low++;
    if (bus.ready_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("ready_unexpected", 128'd1, 128'd0);
      end else begin
        ek = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        chk("prev_key", bus.prev_key_out, ek);
        chk("ready_latency", 128'(cyc), 128'(ec));
        chk("busy_at_ready", 128'(bus.busy_out), 128'd0);
      end
    end
    if (bus.err_out === 1'b1) begin
      if (err_cyc_q.size() == 0) begin
        chk("err_unexpected", 128'd1, 128'd0);
      end else begin
        ec = err_cyc_q.pop_front();
        chk("err_cycle", 128'(cyc), 128'(ec));
      end
    end
  end

  task automatic step(input logic [127:0] key, input logic [3:0] r,
                      input logic [127:0] exp, input bit disturb);
    bus.start_in   = 1'b1;
    bus.round_in   = r;
    bus.cur_key_in = to_port(key);
    exp_q.push_back(to_port(exp));
    exp_cyc_q.push_back(cyc + 6);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_in_q1", 128'(bus.busy_out), 128'd1);
      if (disturb && i < 6) begin
        bus.start_in   = 1'b1;
        bus.round_in   = 4'(i - 1);
        bus.cur_key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        bus.start_in = 1'b0;
      end
    end
  endtask

  task automatic bad_start(input logic [3:0] r);
    bus.start_in   = 1'b1;
    bus.round_in   = r;
    bus.cur_key_in = {4{32'hdeadbeef}};
    err_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    bus.start_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, e;
    int ce0;
    bus.start_in   = 1'b0;
    bus.round_in   = 4'd0;
    bus.cur_key_in = '0;

    @(negedge clk);
    chk("rst_prev", bus.prev_key_out, 128'd0);
    chk("rst_ready", 128'(bus.ready_out), 128'd0);
    chk("rst_busy", 128'(bus.busy_out), 128'd0);
    chk("rst_err", 128'(bus.err_out), 128'd0);
    chk("rst_addr", 128'(bus.sbox_addr_out), 128'd0);
    chk("rst_ce", 128'(bus.ce), 128'd1);
    chk("rst_re", 128'(bus.re), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    step(K_R10, 4'd10, K_R9, 1'b0);
    repeat (3) @(negedge clk);
    step(K_R1, 4'd1, K_R0, 1'b0);
    repeat (3) @(negedge clk);

    ce0 = ce_low;
    k = K_R10;
    for (int r = 10; r >= 1; r--) begin
      e = (r == 1) ? K_R0 : inv_step_ref(k, r);
      step(k, 4'(r), e, 1'b0);
      k = e;
    end
    repeat (2) @(negedge clk);
    chk("chain_ce_low_cycles", 128'(ce_low - ce0), 128'd40);

    ce0 = ce_low;
    bad_start(4'd0);
    bad_start(4'd11);
    repeat (3) @(negedge clk);
    chk("bad_start_ce_quiet", 128'(ce_low - ce0), 128'd0);
    chk("bad_start_prev_hold", bus.prev_key_out, to_port(K_R0));

    step(K_R1, 4'd1, K_R0, 1'b1);
    repeat (3) @(negedge clk);

    bus.start_in   = 1'b1;
    bus.round_in   = 4'd10;
    bus.cur_key_in = to_port(K_R10);
    @(negedge clk);
    bus.start_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_prev", bus.prev_key_out, 128'd0);
    chk("midrst_ready", 128'(bus.ready_out), 128'd0);
    chk("midrst_busy", 128'(bus.busy_out), 128'd0);
    chk("midrst_err", 128'(bus.err_out), 128'd0);
    chk("midrst_addr", 128'(bus.sbox_addr_out), 128'd0);
    chk("midrst_ce", 128'(bus.ce), 128'd1);
    chk("midrst_re", 128'(bus.re), 128'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    step(K_R1, 4'd1, K_R0, 1'b0);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || err_cyc_q.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("ready_queue_drained", 128'(exp_q.size()), 128'd0);
    chk("err_queue_drained", 128'(err_cyc_q.size()), 128'd0);
    chk("re_tracks_ce", 128'(re_bad), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low.
REQ-003 start_in  input  1  request one inverse step; sampled only in IDLE.
REQ-004 round_in  input  4  index r (1..10) of the round key supplied; selects rcon(r).
REQ-005 cur_key_in  input  128  round key K_r.
REQ-006 sbox_data_in  input  8  forward S-box result, valid the cycle after the S-box samples a request.
REQ-007 prev_key_out  output  128  registered K_(r-1).
REQ-008 ready_out  output  1  one-cycle pulse; prev_key_out valid from that cycle on.
REQ-009 busy_out  output  1  high from start acceptance until ready_out.
REQ-010 err_out  output  1  one-cycle pulse on rejected start.
REQ-011 sbox_addr_out  output  8  registered S-box address.
REQ-012 ce  output  1  active-low S-box chip enable, registered.
REQ-013 re  output  1  active-low S-box read enable, registered; equals ce.

Function
REQ-014 Key layout: byte(row i, col c) = bits [127-32i-8c -: 8]; word Wc = {byte(0,c),byte(1,c),byte(2,c),byte(3,c)}.
REQ-015 Output words: P3=W3^W2; P2=W2^W1; P1=W1^W0; P0 = W0 ^ SubWord(RotWord(P3)) ^ {rcon(r),24'h0}.
REQ-016 rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36.
REQ-017 FSM states: IDLE, Q1, Q2, Q3, Q4, DONE; any undefined encoding returns to IDLE.
REQ-018 IDLE: start_in=1 with r in 1..10 at edge E0 latches cur_key_in and rcon, forms P3, drives sbox_addr_out = P3 byte1, ce=re=0, enters Q1.
REQ-019 Q1..Q3 (edges E1..E3): capture sbox_data_in, request P3 byte2, byte3, then byte0 in turn.
REQ-020 Q4 (edge E4): capture byte3 result; ce=re=1 thereafter.
REQ-021 DONE (edge E5): capture byte0 result, assemble SubWord(RotWord(P3)) = {S(b1),S(b2),S(b3),S(b0)}, load prev_key_out, ready_out=1 for exactly one cycle, return to IDLE.
REQ-022 Latency: ready_out high the cycle after E5; ce/re low for exactly 4 consecutive cycles per step.
REQ-023 start_in while busy is ignored; no error raised.
REQ-024 start_in in IDLE with r=0 or r>10: no step, no S-box access, err_out one-cycle pulse, prev_key_out unchanged.
REQ-025 cur_key_in and round_in changes after E0 do not affect the step in progress.
REQ-026 prev_key_out holds its value until the next ready_out.
REQ-027 start_in high in the ready_out cycle (now IDLE) is accepted, giving back-to-back steps every 6 cycles.

Reset
REQ-028 With rst low: state=IDLE, prev_key_out=0, ready_out=0, busy_out=0, err_out=0, sbox_addr_out=0, ce=re=1, latched key and S-box capture registers = 0.
REQ-029 Reset asserted mid-step aborts the step, no ready_out pulse; the first start after release proceeds normally.

Structure
REQ-030 Shared AES package holds the rcon table/function, state-encoding constants and the byte/word index helpers; the forward key schedule uses the same package.
REQ-031 Single module, no sub-modules; the S-box is external and shared through the ce/re/address port.

Verification
REQ-032 FIPS-197 A.1: r=10, key d014f9a8c9ee2589e13f0cc8b6630ca6 (words) -> prev_key_out ac7766f319fadc2128d12941575c006e, ready_out 6 cycles after the start edge.
REQ-033 r=1, key a0fafe1788542cb123a339392a6c7605 -> 2b7e151628aed2a6abf7158809cf4f3c.
REQ-034 Chain 10 back-to-back steps from the round-10 key -> the cipher key; ce low exactly 40 cycles in total.
REQ-035 start with r=0, then r=11 -> err_out pulses, ce stays high, prev_key_out unchanged.
REQ-036 Reset asserted in Q2 -> all outputs at reset values, no ready_out; the following r=1 step still gives the correct result.
REQ-037 Change cur_key_in and pulse start_in during Q1..DONE -> result matches the E0 inputs; the extra start is ignored.
